warp_icache_dm: RTL and testbench
=================================

// Module: warp_icache_dm
// PURPOSE
//  Parametrised direct-mapped instruction cache; successor to the fixed single-line fetch cache.
//  Sits between the fetch unit and the AHB-Lite fabric; answers 64-bit fetches, refills whole lines.
//  Refill uses fixed-length bursts, with optional critical-word-first. Read-only, no writes/snoop.
// PARAMETERS
//  ADDR_W      64  fetch/AHB address width
//  LINE_WORDS  4   64-bit words per line; legal 4, 8, 16 (maps to 4/8/16-beat bursts)
//  SETS        16  number of lines; power of two >= 2
// PORTS
//  i_clk          in   1       sole clock; AHB HCLK is the same clock
//  i_rst          in   1       asynchronous, active-high reset
//  i_req_valid    in   1       fetch request; accepted when i_req_valid && o_req_ready
//  o_req_ready    out  1       high only in IDLE
//  i_req_raddr    in   ADDR_W  fetch byte address; bits [2:0] ignored
//  o_res_valid    out  1       one-cycle response strobe
//  o_res_rdata    out  64      fetched word, valid with o_res_valid
//  o_res_err      out  1       bus error on refill, valid with o_res_valid
//  o_ahb_haddr    out  ADDR_W  AHB address
//  o_ahb_htrans   out  2       IDLE/NONSEQ/SEQ only (never BUSY)
//  o_ahb_hburst   out  3       WRAPn or INCRn, n=LINE_WORDS
//  o_ahb_hsize    out  3       constant 3'b011 (64-bit)
//  o_ahb_hprot    out  4       constant 4'b0010 (opcode fetch, privileged)
//  o_ahb_hwrite   out  1       constant 0
//  i_ahb_hrdata   in   64      read data
//  i_ahb_hready   in   1       transfer done / stall when low
//  i_ahb_hresp    in   1       1 = ERROR
// BEHAVIOUR
//  Address split: [2:0] byte, next OFF_W=$clog2(LINE_WORDS) word offset, next IDX_W=$clog2(SETS) index, rest tag.
//  Reset: all valid bits 0, state IDLE, o_res_valid/o_res_err/o_res_rdata 0, htrans IDLE, haddr 0.
//  States: IDLE -> (hit) RESP -> IDLE; IDLE -> (miss) REFILL -> (last beat done) IDLE; REFILL -> (hresp) ERR -> IDLE.
//  Hit: accept at edge N, o_res_valid=1 for exactly the cycle after edge N+1 (one-cycle lookup, registered data).
//  Miss: NONSEQ on the cycle after accept, then SEQ beats; address phase k+1 overlaps data phase k (pipelined).
//  i_ahb_hready low: haddr/htrans/hburst held unchanged; no beat counted; no data captured.
//  Each completed data beat writes its word into the data array at (index, beat address offset).
//  Tag and valid written only when the final beat completes without error; prior line contents lost on miss start.
//  Error: hresp=1 with hready=0 (first ERROR cycle) -> htrans IDLE next cycle; o_res_valid+o_res_err pulse
//   after the second ERROR cycle; line left invalid; o_res_rdata=0.
//  o_res_valid never asserts twice for one request; o_req_ready is low from accept until response cycle.
//  Response in same cycle as i_req_valid: request not accepted (ready low); next request accepted earliest the cycle after.
//  Reset mid-refill: burst abandoned immediately (htrans IDLE asynchronously), no response, all lines invalid.
// CONFIGURATION
//  WARP_ICACHE_CWF_EN defined: hburst=WRAPn, first haddr = requested word; o_res_valid the cycle after
//   the first beat completes (refill continues, o_req_ready stays low until last beat).
//  Undefined: hburst=INCRn, first haddr = line base; o_res_valid the cycle after the last beat,
//   data taken from the filled line.
// STRUCTURE
//  warp_ahb_pkg: HTRANS_*, HBURST_*, HSIZE_64 constants; htrans_t/hburst_t typedefs; burst-for-length function.
//  Sub-module warp_icache_dm_ram: SETS*LINE_WORDS x 64 data array, one write port, registered read port.
//  Tag/valid arrays and FSM stay in warp_icache_dm.
// TESTING (defaults; memory word at byte addr A = 64'hC0DE_0000_0000_0000 | A)
//  Cold fetch 0x08 -> one 4-beat burst, o_res_rdata=64'hC0DE_0000_0000_0008, res_err=0.
//  Repeat fetch 0x10 after fill -> no AHB activity (htrans IDLE), res_valid one cycle after accept edge.
//  CWF on, fetch 0x18 -> haddr 0x18,0x00,0x08,0x10, WRAP4; res_valid after first beat. CWF off -> 0x00..0x18 INCR4.
//  Fetch 0x200 after 0x00 filled -> miss (same index 0), refill; then 0x00 misses again.
//  hresp ERROR on beat 2 -> htrans IDLE after first ERROR cycle, res_err=1; refetch re-issues full burst.
//  hready low 3 cycles mid-burst -> haddr held; data correct; i_rst pulse mid-burst -> htrans IDLE, no res_valid.

Source files
------------

// File: rtl/warp_ahb_pkg.sv
// AHB-Lite encodings shared by the fetch-side blocks:
// transfer types, burst types, transfer size and burst selection.
package warp_ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_t;

  localparam logic [2:0] HSIZE_64 = 3'b011;
  localparam logic [3:0] HPROT_FETCH = 4'b0010;

  function automatic hburst_t burst_for_len(
    input int unsigned words,
    input logic        wrap
  );
    hburst_t b;
    unique case (words)
      8:       b = wrap ? HBURST_WRAP8 : HBURST_INCR8;
      16:      b = wrap ? HBURST_WRAP16 : HBURST_INCR16;
      default: b = wrap ? HBURST_WRAP4 : HBURST_INCR4;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/warp_icache_dm_ram.sv
// Line data array for warp_icache_dm: one write port,
// one read port with registered output.
module warp_icache_dm_ram #(
  parameter int AW = 6
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [63:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [63:0]   o_rdata
);

  logic [63:0] mem [2**AW];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
    o_rdata <= mem[i_raddr];
  end

endmodule

// File: rtl/warp_icache_dm.sv
// Direct-mapped instruction cache with AHB-Lite burst refill.
// WARP_ICACHE_CWF_EN: wrapping critical-word-first refill.
module warp_icache_dm
  import warp_ahb_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_raddr,
  output logic              o_res_valid,
  output logic [63:0]       o_res_rdata,
  output logic              o_res_err,
  output logic [ADDR_W-1:0] o_ahb_haddr,
  output logic [1:0]        o_ahb_htrans,
  output logic [2:0]        o_ahb_hburst,
  output logic [2:0]        o_ahb_hsize,
  output logic [3:0]        o_ahb_hprot,
  output logic              o_ahb_hwrite,
  input  logic [63:0]       i_ahb_hrdata,
  input  logic              i_ahb_hready,
  input  logic              i_ahb_hresp
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - 3 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST = OFF_W'(LINE_WORDS - 1);
  localparam logic [OFF_W:0]   NBEAT = (OFF_W + 1)'(LINE_WORDS);
`ifdef WARP_ICACHE_CWF_EN
  localparam logic CWF = 1'b1;
`else
  localparam logic CWF = 1'b0;
`endif
  localparam hburst_t BURST = burst_for_len(LINE_WORDS, CWF);

  typedef enum logic [1:0] {
    S_IDLE, S_RESP, S_REFILL, S_ERR
  } state_t;

  state_t state_q, state_d;

  logic [TAG_W-1:0] tag_q [SETS];
  logic [SETS-1:0]  vld_q;

  logic [TAG_W-1:0] in_tag, req_tag_q;
  logic [IDX_W-1:0] in_idx, req_idx_q;
  logic [OFF_W-1:0] in_off, req_off_q;
  logic [OFF_W-1:0] first_off, nxt_off;
  logic [OFF_W-1:0] dph_off_q, dcnt_q;
  logic [OFF_W:0]   acnt_q;
  logic             dph_q, resp_done_q;
  logic [63:0]      crit_q, ram_q, rdata_q;
  logic             res_valid_q, res_err_q;
  logic [ADDR_W-1:0] haddr_q;
  htrans_t          htrans_q;

  logic hit, accept, err_first;
  logic beat_done, last_beat, crit_hit;
  logic unused_lsb;

  assign in_tag = i_req_raddr[ADDR_W-1 -: TAG_W];
  assign in_idx = i_req_raddr[OFF_W+3 +: IDX_W];
  assign in_off = i_req_raddr[3 +: OFF_W];
  assign unused_lsb = ^i_req_raddr[2:0];
  assign first_off = CWF ? in_off : {OFF_W{1'b0}};
  assign nxt_off = haddr_q[3 +: OFF_W] + OFF_W'(1);

  assign o_req_ready  = (state_q == S_IDLE) && !res_valid_q;
  assign o_res_valid  = res_valid_q;
  assign o_res_err    = res_err_q;
  assign o_res_rdata  = rdata_q;
  assign o_ahb_haddr  = haddr_q;
  assign o_ahb_htrans = htrans_q;
  assign o_ahb_hburst = BURST;
  assign o_ahb_hsize  = HSIZE_64;
  assign o_ahb_hprot  = HPROT_FETCH;
  assign o_ahb_hwrite = 1'b0;

  always_comb begin
    hit       = vld_q[in_idx] && (tag_q[in_idx] == in_tag);
    accept    = i_req_valid && o_req_ready;
    err_first = dph_q && i_ahb_hresp && !i_ahb_hready;
    beat_done = (state_q == S_REFILL) && dph_q &&
                i_ahb_hready && !i_ahb_hresp;
    last_beat = beat_done && (dcnt_q == LAST);
    crit_hit  = (dph_off_q == req_off_q);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (accept) state_d = hit ? S_RESP : S_REFILL;
      S_RESP:   state_d = S_IDLE;
      S_REFILL: begin
        if (err_first)      state_d = S_ERR;
        else if (last_beat) state_d = S_IDLE;
      end
      S_ERR:    if (i_ahb_hready) state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (last_beat) tag_q[req_idx_q] <= req_tag_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_q       <= '0;
      req_tag_q   <= '0;
      req_idx_q   <= '0;
      req_off_q   <= '0;
      haddr_q     <= '0;
      htrans_q    <= HTRANS_IDLE;
      acnt_q      <= '0;
      dcnt_q      <= '0;
      dph_q       <= 1'b0;
      dph_off_q   <= '0;
      resp_done_q <= 1'b0;
      crit_q      <= '0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      rdata_q     <= '0;
    end else begin
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            req_tag_q <= in_tag;
            req_idx_q <= in_idx;
            req_off_q <= in_off;
            if (!hit) begin
              vld_q[in_idx] <= 1'b0;
              haddr_q <= {in_tag, in_idx, first_off, 3'b000};
              htrans_q <= HTRANS_NONSEQ;
              acnt_q <= (OFF_W + 1)'(1);
              dcnt_q <= '0;
              dph_q <= 1'b0;
              resp_done_q <= 1'b0;
            end
          end
        end
        S_RESP: begin
          res_valid_q <= 1'b1;
          rdata_q     <= ram_q;
        end
        S_REFILL: begin
          if (err_first) begin
            // ERROR needs two cycles; cancel the pending address now
            htrans_q <= HTRANS_IDLE;
            dph_q    <= 1'b0;
          end else if (i_ahb_hready) begin
            dph_q     <= (htrans_q != HTRANS_IDLE);
            dph_off_q <= haddr_q[3 +: OFF_W];
            if (htrans_q != HTRANS_IDLE) begin
              if (acnt_q == NBEAT) begin
                htrans_q <= HTRANS_IDLE;
              end else begin
                haddr_q  <= {haddr_q[ADDR_W-1:OFF_W+3], nxt_off, 3'b000};
                htrans_q <= HTRANS_SEQ;
                acnt_q   <= acnt_q + 1'b1;
              end
            end
            if (beat_done) begin
              dcnt_q <= dcnt_q + 1'b1;
              if (crit_hit) crit_q <= i_ahb_hrdata;
              if (CWF && !resp_done_q) begin
                res_valid_q <= 1'b1;
                rdata_q     <= i_ahb_hrdata;
                resp_done_q <= 1'b1;
              end
              if (last_beat) begin
                vld_q[req_idx_q] <= 1'b1;
                if (!CWF) begin
                  res_valid_q <= 1'b1;
                  rdata_q <= crit_hit ? i_ahb_hrdata : crit_q;
                end
              end
            end
          end
        end
        S_ERR: begin
          if (i_ahb_hready && !resp_done_q) begin
            res_valid_q <= 1'b1;
            res_err_q   <= 1'b1;
            rdata_q     <= '0;
          end
        end
      endcase
    end
  end

  warp_icache_dm_ram #(
    .AW(IDX_W + OFF_W)
  ) u_ram (
    .i_clk  (i_clk),
    .i_we   (beat_done),
    .i_waddr({req_idx_q, dph_off_q}),
    .i_wdata(i_ahb_hrdata),
    .i_raddr({in_idx, in_off}),
    .o_rdata(ram_q)
  );

endmodule

// File: tb/tb_warp_icache_dm.sv
// Scoreboard bench for warp_icache_dm against an AHB-Lite
// memory model with injectable wait states and ERROR.
module tb_warp_icache_dm;
  import warp_ahb_pkg::*;

  localparam logic [63:0] MEMTAG = 64'hC0DE_0000_0000_0000;
`ifdef WARP_ICACHE_CWF_EN
  localparam bit CWF = 1'b1;
  localparam int MISS_LAT = 2;
  localparam int STALL_LAT = 2;
  localparam logic [2:0] EXP_BURST = 3'b010;
`else
  localparam bit CWF = 1'b0;
  localparam int MISS_LAT = 5;
  localparam int STALL_LAT = 8;
  localparam logic [2:0] EXP_BURST = 3'b011;
`endif

  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_ready;
  logic [63:0] req_raddr;
  logic res_valid, res_err;
  logic [63:0] res_rdata;
  logic [63:0] haddr;
  logic [1:0] htrans;
  logic [2:0] hburst, hsize;
  logic [3:0] hprot;
  logic hwrite;
  logic [63:0] hrdata;
  logic hready, hresp;

  always #5 clk = ~clk;

  warp_icache_dm dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_raddr (req_raddr),
    .o_res_valid (res_valid),
    .o_res_rdata (res_rdata),
    .o_res_err   (res_err),
    .o_ahb_haddr (haddr),
    .o_ahb_htrans(htrans),
    .o_ahb_hburst(hburst),
    .o_ahb_hsize (hsize),
    .o_ahb_hprot (hprot),
    .o_ahb_hwrite(hwrite),
    .i_ahb_hrdata(hrdata),
    .i_ahb_hready(hready),
    .i_ahb_hresp (hresp)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_rsp = -1;

  typedef struct packed {
    logic [63:0] d;
    logic        e;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // AHB memory model
  logic [63:0] trace[$];
  logic [2:0] burst_seen = 3'b000;
  logic dp_valid, err_ph, err_now, stall_now;
  logic [63:0] dp_addr;
  int dp_beat, nxt_beat, stall_cnt;
  int err_beat = -1;
  int stall_beat = -1;
  int stall_len = 0;

  always_comb begin
    err_now = dp_valid && (dp_beat == err_beat);
    stall_now = dp_valid && !err_now && (dp_beat == stall_beat) &&
                (stall_cnt > 0);
    hready = !((err_now && !err_ph) || stall_now);
    hresp = err_now;
    hrdata = dp_valid ? (MEMTAG | dp_addr) : 64'd0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_valid <= 1'b0;
      dp_addr <= '0;
      dp_beat <= 0;
      nxt_beat <= 0;
      stall_cnt <= 0;
      err_ph <= 1'b0;
    end else begin
      err_ph <= err_now && !err_ph;
      if (stall_now) stall_cnt <= stall_cnt - 1;
      if (hready) begin
        if (htrans != 2'b00) begin
          dp_valid <= 1'b1;
          dp_addr <= haddr;
          trace.push_back(haddr);
          if (htrans == 2'b10) begin
            dp_beat <= 0;
            nxt_beat <= 1;
            stall_cnt <= stall_len;
            burst_seen <= hburst;
          end else begin
            dp_beat <= nxt_beat;
            nxt_beat <= nxt_beat + 1;
          end
        end else begin
          dp_valid <= 1'b0;
        end
      end
    end
  end

  // monitor: bus-hold rules and response scoreboard
  logic hr_s = 1'b1;
  logic hresp_s = 1'b0;
  logic [63:0] haddr_s = '0;
  logic [1:0] htrans_s = '0;

  always @(posedge clk) begin
    hr_s <= hready;
    hresp_s <= hresp;
    haddr_s <= haddr;
    htrans_s <= htrans;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (!hr_s && !hresp_s && htrans_s != 2'b00) begin
        chk("hold_haddr", haddr, haddr_s);
        chk("hold_htrans", 64'(htrans), 64'(htrans_s));
      end
      if (err_ph) chk("err_htrans_idle", 64'(htrans), 64'd0);
      if (res_valid) begin
        chk("ready_low_on_resp", 64'(req_ready), 64'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_res: got valid data %h expected none",
                   res_rdata);
        end else begin
          e = exp_q.pop_front();
          chk("res_rdata", res_rdata, e.d);
          chk("res_err", 64'(res_err), 64'(e.e));
          last_rsp = cyc;
        end
      end
    end
  end

  task automatic fetch(input logic [63:0] a, input logic [63:0] d,
                       input logic e, input int lat, input int ntr);
    int t;
    int tr0;
    int acc;
    logic [63:0] base;
    logic [63:0] ex;
    logic [1:0] o;
    logic [1:0] ao;
    tr0 = trace.size();
    exp_q.push_back({d, e});
    @(negedge clk);
    req_valid = 1'b1;
    req_raddr = a;
    t = 0;
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got ready 0 expected 1");
    end
    @(posedge clk);
    #1;
    acc = cyc;
    req_valid = 1'b0;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL res_timeout: got no response expected one");
      exp_q.delete();
    end else if (lat >= 0) begin
      chk("latency", 64'(last_rsp - acc), 64'(lat));
    end
    t = 0;
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk("trace_len", 64'(trace.size() - tr0), 64'(ntr));
    base = {a[63:5], 5'b0};
    ao = a[4:3];
    for (int k = 0; k < ntr && tr0 + k < trace.size(); k++) begin
      o = CWF ? ao + 2'(k) : 2'(k);
      ex = base | {59'd0, o, 3'b000};
      chk("haddr_seq", trace[tr0 + k], ex);
    end
    if (ntr > 0) chk("hburst", 64'(burst_seen), 64'(EXP_BURST));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no end expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_raddr = '0;
    repeat (3) @(negedge clk);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_err", 64'(res_err), 64'd0);
    chk("rst_res_rdata", res_rdata, 64'd0);
    chk("rst_htrans", 64'(htrans), 64'd0);
    chk("rst_haddr", haddr, 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("hsize", 64'(hsize), 64'(3'b011));
    chk("hprot", 64'(hprot), 64'(4'b0010));
    chk("hwrite", 64'(hwrite), 64'd0);
    rst = 1'b0;

    fetch(64'h08, MEMTAG | 64'h08, 1'b0, MISS_LAT, 4);
    fetch(64'h10, MEMTAG | 64'h10, 1'b0, 1, 0);
    fetch(64'h218, MEMTAG | 64'h218, 1'b0, MISS_LAT, 4);
    fetch(64'h00, MEMTAG | 64'h00, 1'b0, MISS_LAT, 4);
    fetch(64'h18, MEMTAG | 64'h18, 1'b0, 1, 0);
    fetch(64'h208, MEMTAG | 64'h208, 1'b0, MISS_LAT, 4);

    err_beat = 2;
    if (CWF) fetch(64'h48, MEMTAG | 64'h48, 1'b0, -1, 3);
    else     fetch(64'h48, 64'd0, 1'b1, -1, 3);
    err_beat = -1;
    fetch(64'h48, MEMTAG | 64'h48, 1'b0, MISS_LAT, 4);
    fetch(64'h40, MEMTAG | 64'h40, 1'b0, 1, 0);

    stall_len = 3;
    stall_beat = 1;
    fetch(64'h88, MEMTAG | 64'h88, 1'b0, STALL_LAT, 4);
    stall_beat = -1;
    fetch(64'h98, MEMTAG | 64'h98, 1'b0, 1, 0);

    @(negedge clk);
    req_valid = 1'b1;
    req_raddr = 64'hC8;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("refill_active", 64'(htrans != 2'b00), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_htrans", 64'(htrans), 64'd0);
    chk("midrst_haddr", haddr, 64'd0);
    chk("midrst_res_valid", 64'(res_valid), 64'd0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    repeat (10) @(negedge clk);

    fetch(64'h08, MEMTAG | 64'h08, 1'b0, MISS_LAT, 4);
    fetch(64'h88, MEMTAG | 64'h88, 1'b0, MISS_LAT, 4);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
